// File: rtl/four_12_12_st3_bias_ctrl.sv
// Bias memory controller.
// A load pass streams bias words from the in_* handshake into an external
// memory, starting at address 0. A read pass fetches words from that memory
// in address order and presents them on the out_* handshake. Read data comes
// back one cycle after the request. A 2-entry output FIFO with a bypass path
// absorbs that data, so a word can appear on out_* in the same cycle it
// returns from memory.
module four_12_12_st3_bias_ctrl #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W:0]   cfg_count,
   input  logic              load_start,
   input  logic              read_start,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   output logic              mem_wr_en,
   output logic [ADDR_W-1:0] mem_wr_addr,
   output logic [DATA_W-1:0] mem_wr_data,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic              busy,
   output logic              done,
   output logic              loaded
);

   localparam int CW = ADDR_W + 1;

   typedef enum logic [1:0] {IDLE, LOAD, READ} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_sat, cnt_q;
   logic [CW-1:0]     wr_cnt_q, rd_cnt_q, out_cnt_q;
   logic              inflight_q, loaded_q, done_q;
   logic [DATA_W-1:0] fifo_mem [2];
   logic [1:0]        fifo_cnt_q;
   logic              fifo_wr_idx_q, fifo_rd_idx_q;
   logic [2:0]        occ;
   logic              wr_fire, last_wr, rd_issue, pop, last_pop;
   logic              fifo_push, fifo_pop;
   logic              start_load, start_read, start_empty, pass_end;

   // Requested word count, clipped to the memory size.
   assign cnt_sat = (cfg_count > CW'(DEPTH)) ? CW'(DEPTH) : cfg_count;

   // Write side: each accepted input word becomes one memory write.
   assign in_ready    = (state_q == LOAD) && (wr_cnt_q < cnt_q);
   assign wr_fire     = in_valid && in_ready;
   assign last_wr     = wr_fire && (wr_cnt_q == cnt_q - CW'(1));
   assign mem_wr_en   = wr_fire;
   assign mem_wr_addr = wr_cnt_q[ADDR_W-1:0];
   assign mem_wr_data = in_data;

   // Output side: the FIFO head has priority over data returning from memory.
   // Data on the bypass path is written into the FIFO when it is not popped,
   // so out_data holds steady while out_ready is low.
   assign out_valid = (fifo_cnt_q != 2'd0) || inflight_q;
   assign out_data  = (fifo_cnt_q != 2'd0) ? fifo_mem[fifo_rd_idx_q] :
                      (inflight_q ? mem_rd_data : '0);
   assign pop       = out_valid && out_ready;
   assign last_pop  = pop && (out_cnt_q == cnt_q - CW'(1));
   assign fifo_pop  = pop && (fifo_cnt_q != 2'd0);
   assign fifo_push = inflight_q && !(pop && (fifo_cnt_q == 2'd0));

   // A new read is issued only if its data is sure to have a slot in the FIFO.
   assign occ         = {1'b0, fifo_cnt_q} + {2'b00, inflight_q};
   assign rd_issue    = (state_q == READ) && (rd_cnt_q < cnt_q) &&
                        (occ < (3'd2 + {2'b00, pop}));
   assign mem_rd_en   = rd_issue;
   assign mem_rd_addr = rd_cnt_q[ADDR_W-1:0];

   assign busy   = (state_q != IDLE);
   assign done   = done_q;
   assign loaded = loaded_q;

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next state and pass start/end strobes. A pass with a zero count finishes in IDLE.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_d     = state_q;
      start_load  = 1'b0;
      start_read  = 1'b0;
      start_empty = 1'b0;
      pass_end    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (load_start) begin
               start_load = 1'b1;
               if (cnt_sat == '0) start_empty = 1'b1;
               else               state_d     = LOAD;
            end else if (read_start) begin
               start_read = 1'b1;
               if (cnt_sat == '0) start_empty = 1'b1;
               else               state_d     = READ;
            end
         end
         LOAD: begin
            if (last_wr) begin
               state_d  = IDLE;
               pass_end = 1'b1;
            end
         end
         READ: begin
            if (last_pop) begin
               state_d  = IDLE;
               pass_end = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Counters, status flags, in-flight tracking and FIFO pointers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q         <= '0;
         wr_cnt_q      <= '0;
         rd_cnt_q      <= '0;
         out_cnt_q     <= '0;
         inflight_q    <= 1'b0;
         loaded_q      <= 1'b0;
         done_q        <= 1'b0;
         fifo_cnt_q    <= 2'd0;
         fifo_wr_idx_q <= 1'b0;
         fifo_rd_idx_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments here, so every register updates from pre-edge values.
         done_q     <= pass_end || start_empty;
         inflight_q <= rd_issue;
         if (start_load || start_read) begin
            cnt_q     <= cnt_sat;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            out_cnt_q <= '0;
         end else begin
            if (wr_fire)  wr_cnt_q  <= wr_cnt_q + CW'(1);
            if (rd_issue) rd_cnt_q  <= rd_cnt_q + CW'(1);
            if (pop)      out_cnt_q <= out_cnt_q + CW'(1);
         end
         if (start_load)   loaded_q <= start_empty;
         else if (last_wr) loaded_q <= 1'b1;
         fifo_cnt_q <= fifo_cnt_q + {1'b0, fifo_push} - {1'b0, fifo_pop};
         if (fifo_push) fifo_wr_idx_q <= ~fifo_wr_idx_q;
         if (fifo_pop)  fifo_rd_idx_q <= ~fifo_rd_idx_q;
      end
   end

   // FIFO storage captures returned data that is not consumed on the bypass path.
   always_ff @(posedge clk) begin
      // NOTE: storage has no reset; fifo_cnt_q gates every read, so stale contents are never visible.
      if (fifo_push) fifo_mem[fifo_wr_idx_q] <= mem_rd_data;
   end

endmodule
